// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared stage indices and hazard-controller state type for the 5-stage core's
// pipeline control logic.
package pipeline_ctrl_pkg;

  localparam int NSTAGE     = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_busy_counter.sv
// HI/LO occupancy counter: loads the unit latency on issue, counts down to zero,
// and is cleared when an exception flush kills the in-flight operation.
module muldiv_busy_counter #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  output logic busy
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (load)
      count <= CW'(LAT);
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/bubble/nullify producer: load-use and HI/LO hazards, global memory
// waits, and precise exception/ERET flush sequencing.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int NSTAGE     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_wait,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic              d_use_hilo,
  input  logic              e_load,
  input  logic [4:0]        e_rd,
  input  logic              e_muldiv_start,
  input  logic              d_likely_not_taken,
  input  logic              m_exc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] nullify,
  output logic              pc_redirect_exc,
  output logic              exc_ack,
  output logic              muldiv_busy
);

  import pipeline_ctrl_pkg::*;

  hz_state_t state, state_nxt;
  logic      exc_pending;
  logic      flush;
  logic      load_use;
  logic      md_hazard;
  logic      md_start;
  logic      busy_int;

  // PEND holds a deferred exception; FLUSH is the ack cycle where m_exc is ignored.
  assign exc_pending = (state == PEND) | ((state == RUN) & m_exc);
  assign flush       = exc_pending & ~mem_wait;

  assign load_use = e_load & (e_rd != 5'd0) &
                    ((d_use_rs & (d_rs == e_rd)) | (d_use_rt & (d_rt == e_rd)));
  assign md_hazard = busy_int & d_use_hilo;

  // A stalled E stage re-issues its mul/div later, so only an advancing E may start.
  assign md_start = e_muldiv_start & ~mem_wait & ~flush & ~md_hazard;

  muldiv_busy_counter #(
    .LAT (MULDIV_LAT)
  ) u_muldiv_busy_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (md_start),
    .clear   (flush),
    .busy    (busy_int)
  );

  assign muldiv_busy = busy_int;

  always_comb begin
    stall           = '0;
    bubble          = '0;
    nullify         = '0;
    pc_redirect_exc = 1'b0;
    if (!reset_n) begin
      nullify = '1;
    end else if (mem_wait) begin
      bubble = '1;
    end else if (flush) begin
      nullify         = '1;
      nullify[STG_PC] = 1'b0;
      pc_redirect_exc = 1'b1;
    end else if (md_hazard) begin
      stall[STG_PC]       = 1'b1;
      stall[STG_IF_ID]    = 1'b1;
      stall[STG_ID_EX]    = 1'b1;
      nullify[STG_EX_MEM] = 1'b1;
    end else if (load_use) begin
      stall[STG_PC]      = 1'b1;
      stall[STG_IF_ID]   = 1'b1;
      nullify[STG_ID_EX] = 1'b1;
    end else if (d_likely_not_taken) begin
      nullify[STG_IF_ID] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = RUN;
    if (flush)
      state_nxt = FLUSH;
    else if (exc_pending)
      state_nxt = PEND;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      exc_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      exc_ack <= flush;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and flush controller for the 5-stage core; the producer side of the per-stage stall/bubble/nullify controls consumed by every pipeline register. It detects load-use hazards, tracks the multi-cycle HI/LO unit, absorbs global memory waits, and sequences precise exception/ERET flushes. The block drives one control bit per pipeline boundary (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC redirect select.

## Interface
- MULDIV_LAT, 4, cycles a mul/div occupies HI/LO after issue (1..15)
- NSTAGE, 5, number of controlled registers; index 0=PC, 1=IF_ID, 2=ID_EX, 3=EX_MEM, 4=MEM_WB
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- mem_wait  in  1  I- or D-side memory not ready this cycle
- d_rs, d_rt  in  5 each  source registers of the instruction in D
- d_use_rs, d_use_rt  in  1 each  D actually reads that source
- d_use_hilo  in  1  D is mfhi/mflo/mthi/mtlo or mul/div
- e_load  in  1  instruction in E is a load
- e_rd  in  5  destination of the instruction in E
- e_muldiv_start  in  1  mul/div issues from E this cycle
- d_likely_not_taken  in  1  branch-likely in D resolved not taken
- m_exc  in  1  exception or ERET committing in M
- stall  out  NSTAGE  hold register (hazard-local)
- bubble  out  NSTAGE  hold register (global memory wait)
- nullify  out  NSTAGE  load control-cleared value
- pc_redirect_exc  out  1  PC loads exception/EPC target
- exc_ack  out  1  registered one-cycle pulse: flush complete
- muldiv_busy  out  1  HI/LO unit occupied

## Operation
- Priority per cycle (highest first): reset, mem_wait, exception, muldiv hazard, load-use, likely-not-taken.
- mem_wait=1: bubble=all ones, stall=0, nullify=0; no state advances except muldiv counter decrement; m_exc in RUN moves FSM to PEND.
- Load-use: e_load & e_rd!=0 & ((d_use_rs & d_rs==e_rd) | (d_use_rt & d_rt==e_rd)) -> stall[0]=stall[1]=1, nullify[2]=1.
- Muldiv hazard: muldiv_busy & d_use_hilo -> stall[0..2]=1, nullify[3]=1.
- Likely-not-taken (no higher event): nullify[1]=1 (kills delay slot).
- Counter: e_muldiv_start (not suppressed by a same-cycle hazard) loads MULDIV_LAT; else decrements toward 0 when nonzero; muldiv_busy = counter!=0. Start while busy reloads.
- FSM states RUN, PEND, FLUSH:
  - RUN: m_exc & !mem_wait -> flush now: nullify[1..4]=1, pc_redirect_exc=1, counter cleared to 0, go FLUSH. m_exc & mem_wait -> PEND.
  - PEND: all bubble while mem_wait; first cycle mem_wait=0 performs the flush exactly as RUN, go FLUSH. m_exc is not rechecked in PEND.
  - FLUSH: one cycle; exc_ack=1 (registered); m_exc ignored; hazard detection active; next state RUN.
- Flush cycle overrides all hazard stalls: stall=0, bubble=0 everywhere.

## Timing
- All hazard outputs combinational from inputs and state; zero-cycle latency to the register bank.
- Exception: flush in cycle N (or first non-wait cycle), exc_ack high in N+1 only.
- Muldiv: start at cycle N, busy for cycles N+1..N+MULDIV_LAT; D hilo user released in N+MULDIV_LAT+1.
- Reset (async assert, sync release): state RUN, counter 0, exc_ack 0; while reset_n=0 outputs stall=0, bubble=0, nullify=all ones, pc_redirect_exc=0, muldiv_busy=0. Reset mid-flush or mid-muldiv drops everything.
- Counter width $clog2(MULDIV_LAT+1); never wraps below 0.

## Structure
- Package pipeline_ctrl_pkg: stage index constants (STG_PC..STG_MEM_WB), NSTAGE, hz_state_t enum {RUN, PEND, FLUSH}.
- Sub-module muldiv_busy_counter (load, clear, busy) isolates the counter; FSM and priority mux stay top-level.

## Test plan
- Load r5 in E, D reads rs=5 -> stall=5'b00011, nullify=5'b00100 for one cycle; rs=0 with e_rd=0 -> no stall.
- MULDIV_LAT=4, start at cycle 10, mflo in D at 11 -> stall[0..2]=1, nullify[3]=1 for cycles 11-14, released cycle 15.
- m_exc at cycle 20, mem_wait=0 -> nullify=5'b11110, pc_redirect_exc=1 at 20; exc_ack=1 at 21 only.
- m_exc with mem_wait high cycles 30-32 -> bubble=all ones 30-32, flush at 33, exc_ack at 34.
- Exception during busy muldiv plus simultaneous load-use -> flush wins, stall=0, muldiv_busy=0 next cycle.
- reset_n low mid-FLUSH and with counter=3 -> immediate nullify=all ones, muldiv_busy=0, state RUN after release.
